// File: rtl/impl_mem_pkg.sv
// Shared types and constants for the OBI-to-RAM bridge.
package impl_mem_pkg;

    typedef enum logic {IDLE, STALL} state_e;

    localparam logic [31:0] OOB_RDATA          = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED_DEFAULT  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS          = 16'hB400;

endpackage

// File: rtl/impl_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick pseudo-random grant stalls.
module impl_lfsr16
    import impl_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= seed;
        end else if (en) begin
            value_q <= {value_q[14:0], ^(value_q & LFSR_TAPS)};
        end
    end

    assign value = value_q;

endmodule

// File: rtl/impl_obi_mem_bridge.sv
// OBI-style core port to single RAM port bridge with read-data hold and range checking.
// Build macro IMPL_MEM_STALL_EN adds pseudo-random grant back-pressure.
module impl_obi_mem_bridge
    import impl_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned STALL_MAX  = 3,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    logic        in_range;
    logic        acc;
    logic        rvalid_q;
    logic        rd_q;
    logic        oob_q;
    logic        err_q;
    logic [31:0] rdata_q;

    assign in_range = (addr_i >> ADDR_WIDTH) == 32'd0;
    assign acc      = req_i & gnt_o;

`ifdef IMPL_MEM_STALL_EN
    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_load;
    logic             stalled_q, stalled_d;
    logic [15:0]      lfsr;

    impl_lfsr16 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .seed   (LFSR_SEED),
        .en     (1'b1),
        .value  (lfsr)
    );

    assign cnt_load = CNT_W'(32'd1 + (32'(lfsr[3:2]) % STALL_MAX));

    // stalled_q lets a request that already sat out a stall be granted without re-rolling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stalled_d = stalled_q;
        gnt_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!req_i) begin
                    stalled_d = 1'b0;
                end else if ((lfsr[1:0] != 2'b00) && !stalled_q) begin
                    state_d = STALL;
                    cnt_d   = cnt_load;
                end else begin
                    gnt_o     = rst_ni;
                    stalled_d = 1'b0;
                end
            end
            STALL: begin
                cnt_d = cnt_q - 1'b1;
                if (!req_i) begin
                    state_d   = IDLE;
                    stalled_d = 1'b0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    stalled_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
        end
    end

    req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (req_i && $stable({addr_i, we_i, be_i, wdata_i})));
`else
    logic unused_cfg;

    assign gnt_o      = req_i & rst_ni;
    assign unused_cfg = ^{LFSR_SEED, STALL_MAX[0]};
`endif

    assign ram_en_o    = acc & in_range;
    assign ram_we_o    = acc & we_i & in_range;
    assign ram_addr_o  = addr_i[ADDR_WIDTH-1:0];
    assign ram_be_o    = be_i;
    assign ram_wdata_o = wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rd_q     <= 1'b0;
            oob_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= acc;
            rd_q     <= acc & ~we_i & in_range;
            oob_q    <= acc & ~in_range;
            err_q    <= err_q | (acc & ~in_range);
            if (rvalid_q && rd_q) begin
                rdata_q <= ram_rdata_i;
            end
        end
    end

    // RAM read data is only trusted in its own response cycle; elsewhere the port free-runs.
    always_comb begin
        rdata_o = rdata_q;
        if (rvalid_q) begin
            if (oob_q) begin
                rdata_o = OOB_RDATA;
            end else if (rd_q) begin
                rdata_o = ram_rdata_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule
